// File: rtl/shreg_rx_if.sv
// Handshake bundle between the serial source/consumer side and the shreg_rx receiver.
// master drives start/sin/ack; slave (the receiver) drives the word and status.
interface shreg_rx_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sin;
    logic             ack;
    logic [WIDTH-1:0] dout;
    logic             valid;
    logic             busy;
    logic             ovr;

    modport master (
        output start, sin, ack,
        input  dout, valid, busy, ovr
    );

    modport slave (
        input  start, sin, ack,
        output dout, valid, busy, ovr
    );
endinterface

// File: rtl/shreg_rx.sv
// Serial-to-parallel receiver for the MSB-first stream of the upstream shift register.
// Reassembles WIDTH-bit frames and presents them with a valid/ack hold handshake and sticky overrun.
module shreg_rx #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    shreg_rx_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-2:0] sr;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dout_q;
    logic             valid_q;
    logic             ovr_q;
    logic             take, last, busy_c;
    logic [WIDTH-1:0] word;

    // The incoming bit always lands in the LSB; the low WIDTH-1 bits feed sr back.
    assign word = {sr, bus.sin};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (cnt == LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        take   = 1'b0;
        last   = 1'b0;
        busy_c = 1'b0;
        case (state)
            IDLE: take = bus.start;
            SHIFT: begin
                busy_c = 1'b1;
                last   = (cnt == LAST);
                take   = (cnt != LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr      <= '0;
            cnt     <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (take) begin
                sr  <= word[WIDTH-2:0];
                cnt <= busy_c ? cnt + CNT_W'(1) : CNT_W'(1);
            end
            if (last) begin
                // A new word always wins; an unacknowledged old one is an overrun.
                cnt     <= '0;
                dout_q  <= word;
                valid_q <= 1'b1;
                if (valid_q && !bus.ack) ovr_q <= 1'b1;
            end else if (valid_q && bus.ack) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.dout  = dout_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_c;
    assign bus.ovr   = ovr_q;
endmodule

// File: tb/tb_shreg_rx.sv
// Bench for shreg_rx: reset, table-driven single frame, handshake corner cases,
// then randomized traffic against a frame-level reference model.
module tb_shreg_rx;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shreg_rx_if #(.WIDTH(WIDTH)) bus ();

    shreg_rx #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_total = 0;
    int n_pass  = 0;
    int done_cnt = 0;
    logic prev_busy = 1'b0;

    // Reference model: collects a frame as a list of bits, packs it when complete.
    bit             m_in_frame;
    bit             m_bits[$];
    logic [WIDTH-1:0] m_dout;
    logic           m_valid;
    logic           m_ovr;

    typedef struct {
        logic             start;
        logic             sin;
        logic             ack;
        logic [WIDTH-1:0] dout;
        logic             valid;
        logic             busy;
        logic             ovr;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_in_frame = 0;
        m_bits.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic model_edge(input logic st, input logic si, input logic ak);
        bit comp;
        logic [WIDTH-1:0] w;
        comp = 0;
        w = '0;
        if (!m_in_frame) begin
            if (st) begin
                m_bits.push_back(si);
                m_in_frame = 1;
            end
        end else begin
            m_bits.push_back(si);
            if (m_bits.size() == WIDTH) begin
                comp = 1;
                foreach (m_bits[i]) w = {w[WIDTH-2:0], m_bits[i]};
                m_bits.delete();
                m_in_frame = 0;
            end
        end
        if (comp) begin
            if (m_valid && !ak) m_ovr = 1'b1;
            m_valid = 1'b1;
            m_dout  = w;
        end else if (ak) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(bus.start, bus.sin, bus.ack);
        #1;
        if (prev_busy && !bus.busy) done_cnt++;
        prev_busy = bus.busy;
        check("m_dout",  32'(bus.dout),  32'(m_dout));
        check("m_valid", 32'(bus.valid), 32'(m_valid));
        check("m_busy",  32'(bus.busy),  32'(m_in_frame));
        check("m_ovr",   32'(bus.ovr),   32'(m_ovr));
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0;
        bus.sin   = 1'b0;
        bus.ack   = 1'b0;
    endtask

    // Entered at posedge+1; rst rises mid-cycle and outputs must clear with no edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_dout",  32'(bus.dout),  32'h0);
        check("rst_valid", 32'(bus.valid), 32'h0);
        check("rst_busy",  32'(bus.busy),  32'h0);
        check("rst_ovr",   32'(bus.ovr),   32'h0);
        model_reset();
        prev_busy = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] w, input int ack_bit, input bit start_all);
        for (int i = 0; i < WIDTH; i++) begin
            bus.start = (i == 0) || start_all;
            bus.sin   = w[WIDTH-1-i];
            bus.ack   = (i == ack_bit);
            step();
        end
        idle_inputs();
    endtask

    initial begin
        int d0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("init_valid", 32'(bus.valid), 32'h0);
        check("init_dout",  32'(bus.dout),  32'h0);

        // Single frame 0x7F, ack two edges after completion.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        for (int i = 1; i < 7; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            bus.start = tbl[i].start;
            bus.sin   = tbl[i].sin;
            bus.ack   = tbl[i].ack;
            step();
            check($sformatf("tbl%0d_dout", i),  32'(bus.dout),  32'(tbl[i].dout));
            check($sformatf("tbl%0d_valid", i), 32'(bus.valid), 32'(tbl[i].valid));
            check($sformatf("tbl%0d_busy", i),  32'(bus.busy),  32'(tbl[i].busy));
            check($sformatf("tbl%0d_ovr", i),   32'(bus.ovr),   32'(tbl[i].ovr));
        end
        idle_inputs();

        // Asynchronous reset with a held word and an in-flight frame.
        send_frame(8'hE1, -1, 0);
        bus.start = 1'b1; bus.sin = 1'b1;
        step();
        do_reset();

        // Back-to-back frames, first word acked during the second frame.
        send_frame(8'hA5, -1, 0);
        check("b2b_dout1",  32'(bus.dout),  32'hA5);
        check("b2b_valid1", 32'(bus.valid), 32'h1);
        send_frame(8'h3C, 2, 0);
        check("b2b_dout2",  32'(bus.dout),  32'h3C);
        check("b2b_valid2", 32'(bus.valid), 32'h1);
        check("b2b_ovr",    32'(bus.ovr),   32'h0);
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        check("b2b_acked", 32'(bus.valid), 32'h0);

        // Overrun: second word lands while the first is unacknowledged.
        send_frame(8'h55, -1, 0);
        send_frame(8'h0F, -1, 0);
        check("ovr_dout",  32'(bus.dout),  32'h0F);
        check("ovr_valid", 32'(bus.valid), 32'h1);
        check("ovr_flag",  32'(bus.ovr),   32'h1);
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        check("ovr_sticky", 32'(bus.ovr),   32'h1);
        check("ovr_ackd",   32'(bus.valid), 32'h0);
        do_reset();

        // Ack coincides with the completion edge of the next word.
        send_frame(8'h11, -1, 0);
        send_frame(8'h22, WIDTH - 1, 0);
        check("coin_dout",  32'(bus.dout),  32'h22);
        check("coin_valid", 32'(bus.valid), 32'h1);
        check("coin_ovr",   32'(bus.ovr),   32'h0);
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;

        // start held high through the frame must not restart it.
        d0 = done_cnt;
        send_frame(8'h96, -1, 1);
        step();
        check("ign_dout",  32'(bus.dout),     32'h96);
        check("ign_count", 32'(done_cnt - d0), 32'h1);
        check("ign_busy",  32'(bus.busy),     32'h0);

        // Abort after four bits, then a clean frame.
        for (int i = 0; i < 4; i++) begin
            bus.start = (i == 0);
            bus.sin   = 1'b1;
            step();
        end
        do_reset();
        send_frame(8'hC3, -1, 0);
        check("abort_dout",  32'(bus.dout),  32'hC3);
        check("abort_valid", 32'(bus.valid), 32'h1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bus.start = ($urandom_range(0, 3) == 0);
            bus.sin   = $urandom_range(0, 1) == 1;
            bus.ack   = ($urandom_range(0, 5) == 0);
            step();
        end
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
